ram_pipe: RTL and testbench

Parametrised two-port synchronous RAM for the albaCore family. Successor to the single-port 16×64K data/program memory. Adds:
- a second read-only port for instruction fetch or debug;
- per-port request/ready handshakes;
- a configurable read pipeline depth with a valid strobe;
- an optional post-reset clear sequencer.

It sits between the core's datapath (port A), fetch/debug logic (port B) and the memory array.

---
 rtl/ram_pipe.sv | 87 ++++++++
 tb/tb_ram_pipe.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/ram_pipe.sv
// ram_pipe: two-port synchronous RAM, pipelined reads with valid strobes; RAM_CLEAR_EN adds a post-reset clear sequencer
module ram_pipe #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int RD_LAT = 1,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_din,
  output logic              a_ready,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_dout,
  input  logic              b_req,
  input  logic [ADDR_W-1:0] b_addr,
  output logic              b_ready,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_dout,
  output logic              busy
);
  typedef enum logic {CLEAR, RUN} state_t;
  state_t state, state_n;
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] ad [RD_LAT];
  logic [DATA_W-1:0] bd [RD_LAT];
  logic [RD_LAT-1:0] av, bv;
  logic a_rd, a_wr, b_rd;
  assign a_ready = state == RUN;
  assign b_ready = state == RUN;
  assign busy = state == CLEAR;
  assign a_rd = a_req && a_ready && !a_we;
  assign a_wr = a_req && a_ready && a_we;
  assign b_rd = b_req && b_ready;
`ifdef RAM_CLEAR_EN
  logic [ADDR_W:0] cnt, cnt_n;
  always_comb begin
    cnt_n = state == CLEAR ? cnt + (ADDR_W+1)'(1) : cnt;
    state_n = cnt_n[ADDR_W] ? RUN : state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      state <= CLEAR;
    end else begin
      cnt <= cnt_n;
      state <= state_n;
    end
`else
  always_comb state_n = state;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= RUN;
    else state <= state_n;
`endif
  always_ff @(posedge clk) begin
`ifdef RAM_CLEAR_EN
    if (busy) mem[cnt[ADDR_W-1:0]] <= '0;
`endif
    if (a_wr) mem[a_addr] <= a_din;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      av <= '0;
      bv <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        ad[i] <= '0;
        bd[i] <= '0;
      end
    end else begin
      av[0] <= a_rd;
      bv[0] <= b_rd;
      if (a_rd) ad[0] <= mem[a_addr];
      if (b_rd) bd[0] <= mem[b_addr];
      for (int i = 1; i < RD_LAT; i++) begin
        av[i] <= av[i-1];
        bv[i] <= bv[i-1];
        if (av[i-1]) ad[i] <= ad[i-1];
        if (bv[i-1]) bd[i] <= bd[i-1];
      end
    end
  assign a_rvalid = av[RD_LAT-1];
  assign b_rvalid = bv[RD_LAT-1];
  assign a_dout = ad[RD_LAT-1];
  assign b_dout = bd[RD_LAT-1];
endmodule

// File: tb/tb_ram_pipe.sv
// tb_ram_pipe: randomized check of ram_pipe at RD_LAT 1/3/4 against a calendar-based reference model
module tb_ram_pipe;
  localparam int AW = 7;
  localparam int N = 3;
  localparam int CLR_CYC =
`ifdef RAM_CLEAR_EN
    2**AW;
`else
    0;
`endif
  logic clk = 0, rst_n = 0;
  logic a_req = 0, a_we = 0, b_req = 0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [15:0] a_din = '0;
  logic a_ready [N], a_rvalid [N], b_ready [N], b_rvalid [N], busy [N];
  logic [15:0] a_dout [N], b_dout [N];
  logic [15:0] ref_mem [2**AW];
  bit ev_a [N][8], ev_b [N][8];
  logic [15:0] ed_a [N][8], ed_b [N][8], la [N], lb [N];
  int cyc = 0, clr_left = 0, clr_idx = 0, checks = 0, failures = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < N; g++) begin : g_dut
    ram_pipe #(.DATA_W(16), .ADDR_W(AW), .RD_LAT(g == 0 ? 1 : g + 2)) dut (
      .clk(clk), .rst_n(rst_n),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_din(a_din),
      .a_ready(a_ready[g]), .a_rvalid(a_rvalid[g]), .a_dout(a_dout[g]),
      .b_req(b_req), .b_addr(b_addr),
      .b_ready(b_ready[g]), .b_rvalid(b_rvalid[g]), .b_dout(b_dout[g]),
      .busy(busy[g])
    );
  end
  function automatic int lat(int i);
    return i == 0 ? 1 : i + 2;
  endfunction
  task automatic chk(input string tag, input int i, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s[%0d] cyc=%0d got=%h exp=%h", tag, i, cyc, got, exp);
    end
  endtask
  task automatic sched(input int i, input bit pa, input logic [15:0] d);
    int s;
    s = (cyc + lat(i) - 1) % 8;
    if (pa) begin
      ev_a[i][s] = 1;
      ed_a[i][s] = d;
    end else begin
      ev_b[i][s] = 1;
      ed_b[i][s] = d;
    end
  endtask
  task automatic step();
    bit rdy;
    int s;
    @(posedge clk);
    #1;
    cyc++;
    rdy = clr_left == 0;
    if (rdy && b_req) for (int i = 0; i < N; i++) sched(i, 0, ref_mem[b_addr]);
    if (rdy && a_req) begin
      if (a_we) ref_mem[a_addr] = a_din;
      else for (int i = 0; i < N; i++) sched(i, 1, ref_mem[a_addr]);
    end
    if (clr_left > 0) begin
      ref_mem[clr_idx] = '0;
      clr_idx++;
      clr_left--;
    end
    s = cyc % 8;
    for (int i = 0; i < N; i++) begin
      if (ev_a[i][s]) la[i] = ed_a[i][s];
      if (ev_b[i][s]) lb[i] = ed_b[i][s];
      chk("a_rvalid", i, 16'(a_rvalid[i]), 16'(ev_a[i][s]));
      chk("a_dout", i, a_dout[i], la[i]);
      chk("b_rvalid", i, 16'(b_rvalid[i]), 16'(ev_b[i][s]));
      chk("b_dout", i, b_dout[i], lb[i]);
      chk("a_ready", i, 16'(a_ready[i]), 16'(clr_left == 0));
      chk("b_ready", i, 16'(b_ready[i]), 16'(clr_left == 0));
      chk("busy", i, 16'(busy[i]), 16'(clr_left != 0));
      ev_a[i][s] = 0;
      ev_b[i][s] = 0;
    end
  endtask
  task automatic drive(input bit ar, input bit aw, input int aa, input int ddin, input bit br, input int ba);
    a_req = ar;
    a_we = aw;
    a_addr = AW'(aa);
    a_din = 16'(ddin);
    b_req = br;
    b_addr = AW'(ba);
    step();
  endtask
  task automatic do_reset(input int hold);
    a_req = 0;
    b_req = 0;
    rst_n = 0;
    #1;
    for (int i = 0; i < N; i++) begin
      chk("rst_a_rvalid", i, 16'(a_rvalid[i]), 16'h0);
      chk("rst_a_dout", i, a_dout[i], 16'h0);
      chk("rst_b_rvalid", i, 16'(b_rvalid[i]), 16'h0);
      chk("rst_b_dout", i, b_dout[i], 16'h0);
      la[i] = '0;
      lb[i] = '0;
      for (int k = 0; k < 8; k++) begin
        ev_a[i][k] = 0;
        ev_b[i][k] = 0;
      end
    end
    repeat (hold) @(posedge clk);
    #1;
    rst_n = 1;
    clr_left = CLR_CYC;
    clr_idx = 0;
  endtask
  initial begin
    do_reset(2);
    repeat (CLR_CYC + 3) drive(1, 1, 3, 16'hAAAA, 1, 3);
    drive(1, 0, 3, 0, 0, 0);
    repeat (5) drive(0, 0, 0, 0, 0, 0);
    do_reset(2);
    repeat (7) drive(0, 0, 0, 0, 0, 0);
    do_reset(3);
    repeat (CLR_CYC + 2) drive(0, 0, 0, 0, 0, 0);
`ifdef RAM_CLEAR_EN
    for (int k = 0; k < 2**AW; k++) drive(1, 0, k, 0, 1, 2**AW - 1 - k);
    repeat (5) drive(0, 0, 0, 0, 0, 0);
`endif
    for (int k = 0; k < 2**AW; k++) drive(1, 1, k, int'($urandom_range(16'hFFFF)), 0, 0);
    drive(1, 1, 5, 16'h8105, 0, 0);
    drive(1, 0, 5, 0, 0, 0);
    repeat (6) drive(0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 10; k++) drive(k < 2, 1, 64 + k, 16'h5A00 + k, 1, k);
    repeat (5) drive(0, 0, 0, 0, 0, 0);
    drive(1, 1, 64, 16'hFFFE, 0, 0);
    drive(1, 1, 64, 16'h1234, 1, 64);
    drive(0, 0, 0, 0, 1, 64);
    repeat (5) drive(0, 0, 0, 0, 0, 0);
    drive(1, 0, 10, 0, 1, 11);
    drive(1, 0, 12, 0, 1, 13);
    do_reset(2);
    for (int k = 0; k < 600; k++)
      drive($urandom_range(3) != 0, $urandom_range(1) == 1,
            $urandom_range(1) == 1 ? int'($urandom_range(7)) : int'($urandom_range(2**AW - 1)),
            int'($urandom_range(16'hFFFF)), $urandom_range(3) != 0,
            $urandom_range(1) == 1 ? int'($urandom_range(7)) : int'($urandom_range(2**AW - 1)));
    repeat (6) drive(0, 0, 0, 0, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
